if_stage: RTL

- Instruction-fetch stage of the 5-stage MIPS pipeline: PC register, next-PC selection, instruction-memory request handshake, IF/ID pipeline register.
- Feeds the decode controller directly: supplies ID_instruction and consumes that controller's PC_src.
- Implements stall, flush and redirect, including redirect while an instruction fetch is still outstanding.

---
 rtl/mips_pkg.sv | 23 ++
 rtl/if_id_reg.sv | 59 +++++
 rtl/if_stage.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// ============================================================================
// mips_pkg -- shared encodings for the MIPS front end (PC_src, NOP, fetch FSM)
// Revision: 1.0
// ============================================================================
`default_nettype none

package mips_pkg;

  localparam logic [1:0]  PCSRC_SEQ = 2'b00;
  localparam logic [1:0]  PCSRC_BR  = 2'b01;
  localparam logic [1:0]  PCSRC_J   = 2'b10;
  localparam logic [1:0]  PCSRC_JR  = 2'b11;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    DROP  = 1'b1
  } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/if_id_reg.sv
// ============================================================================
// if_id_reg -- IF/ID pipeline register with load, hold and flush-to-bubble
// Revision: 1.0
// ============================================================================
`default_nettype none

module if_id_reg #(
  parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        flush_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_plus4_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  // Flush outranks load; with neither asserted the register holds.
  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (flush_i) begin
      instr_d = NOP_INSTR;
      pc4_d   = 32'h0000_0000;
      valid_d = 1'b0;
    end else if (load_i) begin
      instr_d = instr_i;
      pc4_d   = pc_plus4_i;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'h0000_0000;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign instr_o    = instr_q;
  assign pc_plus4_o = pc4_q;
  assign valid_o    = valid_q;

endmodule

`default_nettype wire

// File: rtl/if_stage.sv
// ============================================================================
// if_stage -- MIPS instruction fetch: PC, next-PC select, imem handshake, IF/ID
// Revision: 1.0
// ============================================================================
`default_nettype none

module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  PC_src,
  input  logic [31:0] Branch_target,
  input  logic [31:0] ID_rs_data,
  input  logic        Load_use_stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] ID_instruction,
  output logic [31:0] ID_PC_plus4,
  output logic        ID_valid
);

  import mips_pkg::*;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  redir_q, redir_d;
  logic [31:0]  pc_plus4;
  logic [31:0]  target;
  logic         is_branch;
  logic         is_jump;
  logic         redirect;
  logic         id_load;
  logic         id_flush;

  assign pc_plus4  = pc_q + 32'd4;
  assign is_branch = (PC_src == PCSRC_BR);
  // Jumps come from the decoded instruction, so a bubble in ID cannot jump.
  assign is_jump   = ID_valid && ((PC_src == PCSRC_J) || (PC_src == PCSRC_JR));
  assign redirect  = is_branch || (is_jump && !Load_use_stall);

  always_comb begin
    target = pc_plus4;
    case (PC_src)
      PCSRC_BR:  target = Branch_target;
      PCSRC_J:   target = {ID_PC_plus4[31:28], ID_instruction[25:0], 2'b00};
      PCSRC_JR:  target = ID_rs_data;
      PCSRC_SEQ: target = pc_plus4;
      default:   target = pc_plus4;
    endcase
    target[1:0] = 2'b00;
  end

  // PC only moves when a request completes, which keeps imem_addr stable
  // for the whole life of an outstanding request (including through DROP).
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    redir_d  = redir_q;
    id_load  = 1'b0;
    id_flush = 1'b0;
    case (state_q)
      FETCH: begin
        if (redirect) begin
          id_flush = 1'b1;
          if (imem_ready) begin
            pc_d = target;
          end else begin
            redir_d = target;
            state_d = DROP;
          end
        end else if (!Load_use_stall) begin
          if (imem_ready) begin
            id_load = 1'b1;
            pc_d    = pc_plus4;
          end else begin
            id_flush = 1'b1;
          end
        end
      end
      DROP: begin
        id_flush = 1'b1;
        if (imem_ready) begin
          pc_d    = is_branch ? target : redir_q;
          state_d = FETCH;
        end else if (is_branch) begin
          redir_d = target;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      redir_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      redir_q <= redir_d;
    end
  end

  assign imem_req  = reset;
  assign imem_addr = pc_q;

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk        (clk),
    .rst_n      (reset),
    .load_i     (id_load),
    .flush_i    (id_flush),
    .instr_i    (imem_rdata),
    .pc_plus4_i (pc_plus4),
    .instr_o    (ID_instruction),
    .pc_plus4_o (ID_PC_plus4),
    .valid_o    (ID_valid)
  );

endmodule

`default_nettype wire
